h80_uart_io: RTL and testbench



---
 rtl/h80_uart_pkg.sv | 40 ++++
 rtl/h80_uart_rx_fifo.sv | 59 +++++
 rtl/h80_uart_io.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_h80_uart_io.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/h80_uart_pkg.sv
// Shared definitions for the h80 console UART: bus command encodings,
// register offsets, STATUS bit positions and the serial FSM state type.
package h80_uart_pkg;

    typedef logic [2:0]  bus_cmd_t;
    typedef logic [15:0] bus_addr_t;
    typedef logic [15:0] bus_data_t;

    // bit0 set means the master is not driving bus_data
    localparam bus_cmd_t BUS_CMD_NONE    = 3'b001;
    localparam bus_cmd_t BUS_CMD_READ_B  = 3'b011;
    localparam bus_cmd_t BUS_CMD_WRITE_B = 3'b010;

    localparam int unsigned REG_DATA   = 0;
    localparam int unsigned REG_STATUS = 1;

    localparam int unsigned ST_RX_AVAIL = 0;
    localparam int unsigned ST_TX_READY = 1;
    localparam int unsigned ST_OVR      = 2;
    localparam int unsigned ST_FERR     = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } uart_state_t;

    function automatic logic [7:0] status_byte(input logic ferr, input logic ovr,
                                               input logic tx_ready, input logic rx_avail);
        logic [7:0] s;
        s = '0;
        s[ST_FERR]     = ferr;
        s[ST_OVR]      = ovr;
        s[ST_TX_READY] = tx_ready;
        s[ST_RX_AVAIL] = rx_avail;
        return s;
    endfunction

endpackage

// File: rtl/h80_uart_rx_fifo.sv
// Small synchronous FIFO for received bytes. A push into a full FIFO is
// accepted only when a pop happens on the same edge.
module h80_uart_rx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage array, written at the tail
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (PW+1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (PW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/h80_uart_io.sv
// h80 bus I/O responder for the console port: DATA/STATUS registers in
// front of an 8N1 UART with a holding register on TX and a FIFO on RX.
module h80_uart_io
    import h80_uart_pkg::*;
#(
    parameter int unsigned BUS_ADDR_WIDTH = 16,
    parameter int unsigned BUS_CMD_WIDTH  = 3,
    parameter int unsigned BUS_DATA_WIDTH = 16,
    parameter int unsigned BASE_ADDR      = 'h0000,
    parameter int unsigned CLKS_PER_BIT   = 868,
    parameter int unsigned RX_FIFO_DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      iorq_n,
    input  logic [BUS_ADDR_WIDTH-1:0] bus_addr,
    input  logic [BUS_CMD_WIDTH-1:0]  bus_cmd,
    inout  wire  [BUS_DATA_WIDTH-1:0] bus_data,
    output logic                      bus_wait_n,
    input  logic                      rx,
    output logic                      tx
);
    localparam logic [BUS_CMD_WIDTH-1:0]  CMD_NONE    = BUS_CMD_WIDTH'(BUS_CMD_NONE);
    localparam logic [BUS_CMD_WIDTH-1:0]  CMD_READ    = BUS_CMD_WIDTH'(BUS_CMD_READ_B);
    localparam logic [BUS_CMD_WIDTH-1:0]  CMD_WRITE   = BUS_CMD_WIDTH'(BUS_CMD_WRITE_B);
    localparam logic [BUS_ADDR_WIDTH-1:0] ADDR_DATA   = BUS_ADDR_WIDTH'(BASE_ADDR + REG_DATA);
    localparam logic [BUS_ADDR_WIDTH-1:0] ADDR_STATUS = BUS_ADDR_WIDTH'(BASE_ADDR + REG_STATUS);

    localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    // ---------------- bus decode ----------------
    logic       addr_is_data;
    logic       addr_is_status;
    logic       sel;
    logic       is_rd;
    logic       is_wr;
    logic       done;
    logic       data_wr_done;
    logic       data_rd_done;
    logic       stat_rd_done;
    logic [7:0] rd_byte;
    logic       unused_bus_hi;

    // TX holding register and sticky flags
    logic       hold_full;
    logic [7:0] hold_data;
    logic       ovr;
    logic       ferr;

    // FIFO interface
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_head;

    // TX FSM
    uart_state_t      tx_state, tx_state_n;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]       tx_bit, tx_bit_n;
    logic [7:0]       tx_sh, tx_sh_n;
    logic             tx_q, tx_n;
    logic             tx_load;

    // RX FSM
    logic             rx_s1, rx_s2, rx_prev;
    logic             rx_fall;
    uart_state_t      rx_state, rx_state_n;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]       rx_bit, rx_bit_n;
    logic [7:0]       rx_sh, rx_sh_n;
    logic             rx_push;
    logic             ferr_set;
    logic             ovr_set;

    assign addr_is_data   = (bus_addr == ADDR_DATA);
    assign addr_is_status = (bus_addr == ADDR_STATUS);
    assign sel   = !iorq_n && (bus_cmd != CMD_NONE) && (addr_is_data || addr_is_status);
    assign is_rd = (bus_cmd == CMD_READ);
    assign is_wr = (bus_cmd == CMD_WRITE);

    assign bus_wait_n   = !(sel && is_wr && addr_is_data && hold_full);
    assign done         = sel && bus_wait_n;
    assign data_wr_done = done && is_wr && addr_is_data;
    assign data_rd_done = done && is_rd && addr_is_data;
    assign stat_rd_done = done && is_rd && addr_is_status;

    assign rd_byte  = addr_is_data ? (fifo_empty ? 8'h00 : fifo_head)
                                   : status_byte(ferr, ovr, !hold_full, !fifo_empty);
    assign bus_data = (sel && is_rd) ? BUS_DATA_WIDTH'(rd_byte) : 'z;

    assign unused_bus_hi = ^bus_data[BUS_DATA_WIDTH-1:8];

    // Holding register: filled by a DATA write, drained when the TX FSM loads it
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (tx_load) begin
            hold_full <= 1'b0;
        end else if (data_wr_done) begin
            hold_full <= 1'b1;
            hold_data <= bus_data[7:0];
        end
    end

    // Sticky error flags; a new event on the clearing edge wins
    always_ff @(posedge clk) begin
        if (reset) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            ovr  <= ovr_set  || (ovr  && !stat_rd_done);
            ferr <= ferr_set || (ferr && !stat_rd_done);
        end
    end

    // A full FIFO only drops the byte if no pop frees a slot on the same edge
    assign ovr_set = rx_push && fifo_full && !data_rd_done;

    h80_uart_rx_fifo #(
        .DEPTH (RX_FIFO_DEPTH),
        .WIDTH (8)
    ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .din   (rx_sh),
        .pop   (data_rd_done),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // ---------------- TX ----------------
    // TX state register; tx is registered so the pin never glitches
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx_q     <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_sh    <= tx_sh_n;
            tx_q     <= tx_n;
        end
    end

    // TX next state: tx_n is the line level for the state being entered
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_sh_n    = tx_sh;
        tx_n       = tx_q;
        tx_load    = 1'b0;
        unique case (tx_state)
            S_IDLE: begin
                tx_n = 1'b1;
                if (hold_full) begin
                    tx_load    = 1'b1;
                    tx_sh_n    = hold_data;
                    tx_cnt_n   = '0;
                    tx_state_n = S_START;
                    tx_n       = 1'b0;
                end
            end
            S_START: begin
                if (tx_cnt == CNT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                    tx_state_n = S_DATA;
                    tx_n       = tx_sh[0];
                end else begin
                    tx_cnt_n = tx_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (tx_cnt == CNT_LAST) begin
                    tx_cnt_n = '0;
                    if (tx_bit == 3'd7) begin
                        tx_state_n = S_STOP;
                        tx_n       = 1'b1;
                    end else begin
                        tx_bit_n = tx_bit + 3'd1;
                        tx_sh_n  = {1'b0, tx_sh[7:1]};
                        tx_n     = tx_sh[1];
                    end
                end else begin
                    tx_cnt_n = tx_cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (tx_cnt == CNT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_state_n = S_IDLE;
                end else begin
                    tx_cnt_n = tx_cnt + CNT_W'(1);
                end
            end
            default: tx_state_n = S_IDLE;
        endcase
    end

    assign tx = tx_q;

    // ---------------- RX ----------------
    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall = rx_prev && !rx_s2;

    // RX state register
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_sh    <= rx_sh_n;
        end
    end

    // RX next state: half a bit into START, then one sample per bit period
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_sh_n    = rx_sh;
        rx_push    = 1'b0;
        ferr_set   = 1'b0;
        unique case (rx_state)
            S_IDLE: begin
                if (rx_fall) begin
                    rx_cnt_n   = '0;
                    rx_state_n = S_START;
                end
            end
            S_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n = '0;
                    if (rx_s2) begin
                        rx_state_n = S_IDLE;
                    end else begin
                        rx_bit_n   = '0;
                        rx_state_n = S_DATA;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (rx_cnt == CNT_LAST) begin
                    rx_cnt_n = '0;
                    rx_sh_n  = {rx_s2, rx_sh[7:1]};
                    if (rx_bit == 3'd7) begin
                        rx_state_n = S_STOP;
                    end else begin
                        rx_bit_n = rx_bit + 3'd1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (rx_cnt == CNT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_state_n = S_IDLE;
                    if (rx_s2) begin
                        rx_push = 1'b1;
                    end else begin
                        ferr_set = 1'b1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + CNT_W'(1);
                end
            end
            default: rx_state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_h80_uart_io.sv
// Bench for h80_uart_io: bus reads/writes against a small FIFO/flag model,
// TX frames decoded by a line monitor and compared with written bytes.
module tb_h80_uart_io;
    import h80_uart_pkg::*;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        iorq_n = 1'b1;
    logic [15:0] bus_addr = '0;
    logic [2:0]  bus_cmd = BUS_CMD_NONE;
    logic [15:0] tb_drv = '0;
    logic        tb_drv_en = 1'b0;
    wire  [15:0] bus_data;
    logic        bus_wait_n;
    logic        rx = 1'b1;
    logic        tx;

    int checks = 0;
    int failures = 0;
    logic mon_en = 1'b0;

    logic [8:0] tx_got[$];    // {stop, byte} decoded from tx
    logic [7:0] tx_exp[$];    // bytes accepted by DATA writes
    logic [7:0] rx_model[$];  // expected FIFO contents
    logic       ovr_m = 1'b0;
    logic       ferr_m = 1'b0;

    assign bus_data = tb_drv_en ? tb_drv : 16'hzzzz;

    always #5 clk = ~clk;

    h80_uart_io #(
        .BUS_ADDR_WIDTH (16),
        .BUS_CMD_WIDTH  (3),
        .BUS_DATA_WIDTH (16),
        .BASE_ADDR      (0),
        .CLKS_PER_BIT   (CPB),
        .RX_FIFO_DEPTH  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .iorq_n     (iorq_n),
        .bus_addr   (bus_addr),
        .bus_cmd    (bus_cmd),
        .bus_data   (bus_data),
        .bus_wait_n (bus_wait_n),
        .rx         (rx),
        .tx         (tx)
    );

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_status();
        return {12'h000, ferr_m, ovr_m, 1'b1, (rx_model.size() > 0)};
    endfunction

    task automatic bus_idle();
        iorq_n    = 1'b1;
        bus_cmd   = BUS_CMD_NONE;
        tb_drv_en = 1'b0;
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [7:0] d, output int waits);
        iorq_n    = 1'b0;
        bus_addr  = addr;
        bus_cmd   = BUS_CMD_WRITE_B;
        tb_drv    = {8'h00, d};
        tb_drv_en = 1'b1;
        waits     = 0;
        #1;
        while (bus_wait_n !== 1'b1 && waits < 400) begin
            cycles(1);
            waits++;
        end
        checks++;
        if (bus_wait_n !== 1'b1) begin
            failures++;
            $display("FAIL write_stall_bound: bus_wait_n=%b required 1 within 400 cycles", bus_wait_n);
        end else begin
            cycles(1);
            if (addr == 16'h0000) tx_exp.push_back(d);
        end
        bus_idle();
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [15:0] val);
        iorq_n    = 1'b0;
        bus_addr  = addr;
        bus_cmd   = BUS_CMD_READ_B;
        tb_drv_en = 1'b0;
        #1;
        val = bus_data;
        cycles(1);
        bus_idle();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cycles(CPB);
        end
        rx = stop;
        cycles(CPB);
        rx = 1'b1;
        cycles(CPB + 4);
        if (stop) begin
            if (rx_model.size() < 4) rx_model.push_back(b);
            else ovr_m = 1'b1;
        end else begin
            ferr_m = 1'b1;
        end
    endtask

    task automatic wait_tx_frames(input int n);
        int k;
        k = 0;
        while (tx_got.size() < n && k < 600) begin
            cycles(1);
            k++;
        end
        checks++;
        if (tx_got.size() < n) begin
            failures++;
            $display("FAIL tx_frame_bound: got %0d frames required %0d", tx_got.size(), n);
        end
    endtask

    // Line monitor: decode each tx frame at mid-bit
    initial begin
        logic [7:0] b;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && tx === 1'b0) begin
                repeat (CPB / 2) @(posedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(posedge clk);
                    #1;
                    b[i] = tx;
                end
                repeat (CPB) @(posedge clk);
                #1;
                tx_got.push_back({tx, b});
            end
        end
    end

    task automatic test_reset();
        logic [15:0] v;
        reset = 1'b1;
        cycles(3);
        reset = 1'b0;
        mon_en = 1'b1;
        checks++;
        if (tx !== 1'b1) begin
            failures++;
            $display("FAIL reset_tx: got %b required 1", tx);
        end
        bus_read(16'h0001, v);
        checks++;
        if (v !== 16'h0002) begin
            failures++;
            $display("FAIL reset_status: got %h required 0002", v);
        end
        // With iorq_n high the DUT must leave the bus to the bench driver
        iorq_n = 1'b1; bus_cmd = BUS_CMD_READ_B; bus_addr = 16'h0001;
        tb_drv = 16'hA5A4; tb_drv_en = 1'b1;
        #1;
        checks++;
        if (bus_data !== 16'hA5A4) begin
            failures++;
            $display("FAIL idle_bus_float: got %h required A5A4", bus_data);
        end
        bus_idle();
        cycles(1);
    endtask

    task automatic test_tx_single();
        int w;
        logic [15:0] v;
        logic [9:0]  pat;
        logic        tx_bad;
        pat = {1'b1, 8'h41, 1'b0};
        bus_write(16'h0000, 8'h41, w);
        bus_read(16'h0001, v);
        checks++;
        if (v[1] !== 1'b0) begin
            failures++;
            $display("FAIL tx_ready_while_holding: got %b required 0", v[1]);
        end
        tx_bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) cycles(1);
            checks++;
            if (tx !== pat[i / CPB]) begin
                failures++;
                $display("FAIL tx_wave_41 cycle %0d: got %b required %b", i, tx, pat[i / CPB]);
            end
            if (i == 0) begin
                iorq_n = 1'b0; bus_cmd = BUS_CMD_READ_B; bus_addr = 16'h0001;
                #1;
                checks++;
                if (bus_data[1] !== 1'b1) begin
                    failures++;
                    $display("FAIL tx_ready_after_load: got %b required 1", bus_data[1]);
                end
                bus_idle();
            end
        end
        wait_tx_frames(1);
        if (tx_got.size() > 0 && tx_exp.size() > 0) begin
            logic [8:0] g;
            logic [8:0] e;
            g = tx_got.pop_front();
            e = {1'b1, tx_exp.pop_front()};
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL tx_frame_41: got %h required %h", g, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        int w1, w2, w3, n_at;
        bus_write(16'h0000, 8'h55, w1);
        bus_write(16'h0000, 8'hAA, w2);
        bus_write(16'h0000, 8'h0F, w3);
        n_at = tx_got.size();
        checks++;
        if (w1 !== 0) begin
            failures++;
            $display("FAIL b2b_first_wait: got %0d required 0", w1);
        end
        checks++;
        if (w3 < 8 * CPB) begin
            failures++;
            $display("FAIL b2b_third_wait: got %0d cycles required >= %0d", w3, 8 * CPB);
        end
        checks++;
        if (n_at !== 1) begin
            failures++;
            $display("FAIL b2b_third_after_frame1: frames done %0d required 1", n_at);
        end
        wait_tx_frames(3);
        while (tx_got.size() > 0 && tx_exp.size() > 0) begin
            logic [8:0] g;
            logic [8:0] e;
            g = tx_got.pop_front();
            e = {1'b1, tx_exp.pop_front()};
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL b2b_order: got %h required %h", g, e);
            end
        end
    endtask

    task automatic test_rx_single();
        logic [15:0] v;
        logic [15:0] e;
        send_byte(8'h5A, 1'b1);
        e = exp_status();
        bus_read(16'h0001, v);
        ferr_m = 1'b0; ovr_m = 1'b0;
        checks++;
        if (v !== e) begin
            failures++;
            $display("FAIL rx_status_avail: got %h required %h", v, e);
        end
        e = {8'h00, rx_model.pop_front()};
        bus_read(16'h0000, v);
        checks++;
        if (v !== e) begin
            failures++;
            $display("FAIL rx_data_5a: got %h required %h", v, e);
        end
        e = exp_status();
        bus_read(16'h0001, v);
        checks++;
        if (v !== e) begin
            failures++;
            $display("FAIL rx_status_empty: got %h required %h", v, e);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] v;
        logic [15:0] e;
        for (int b = 1; b <= 5; b++) send_byte(8'(b), 1'b1);
        e = exp_status();
        bus_read(16'h0001, v);
        ferr_m = 1'b0; ovr_m = 1'b0;
        checks++;
        if (v !== e) begin
            failures++;
            $display("FAIL ovr_status: got %h required %h", v, e);
        end
        for (int i = 0; i < 4; i++) begin
            e = (rx_model.size() > 0) ? {8'h00, rx_model.pop_front()} : 16'h0000;
            bus_read(16'h0000, v);
            checks++;
            if (v !== e) begin
                failures++;
                $display("FAIL ovr_data_%0d: got %h required %h", i, v, e);
            end
        end
        bus_read(16'h0000, v);
        checks++;
        if (v !== 16'h0000) begin
            failures++;
            $display("FAIL empty_data_read: got %h required 0000", v);
        end
        e = exp_status();
        bus_read(16'h0001, v);
        checks++;
        if (v !== e) begin
            failures++;
            $display("FAIL ovr_cleared: got %h required %h", v, e);
        end
    endtask

    task automatic test_ferr_glitch();
        logic [15:0] v;
        logic [15:0] e;
        send_byte(8'hC3, 1'b0);
        e = exp_status();
        bus_read(16'h0001, v);
        ferr_m = 1'b0; ovr_m = 1'b0;
        checks++;
        if (v !== e) begin
            failures++;
            $display("FAIL ferr_status: got %h required %h", v, e);
        end
        rx = 1'b0;
        cycles(1);
        rx = 1'b1;
        cycles(3 * CPB);
        e = exp_status();
        bus_read(16'h0001, v);
        checks++;
        if (v !== e) begin
            failures++;
            $display("FAIL glitch_status: got %h required %h", v, e);
        end
        bus_read(16'h0000, v);
        checks++;
        if (v !== 16'h0000) begin
            failures++;
            $display("FAIL glitch_data: got %h required 0000", v);
        end
    endtask

    task automatic test_reset_abort();
        int w;
        logic [15:0] v;
        logic bad;
        bus_write(16'h0000, 8'h00, w);
        cycles(12);
        checks++;
        if (tx !== 1'b0) begin
            failures++;
            $display("FAIL abort_midframe_tx: got %b required 0", tx);
        end
        reset = 1'b1;
        cycles(1);
        checks++;
        if (tx !== 1'b1) begin
            failures++;
            $display("FAIL abort_tx_after_reset: got %b required 1", tx);
        end
        cycles(1);
        reset = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            if (tx !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL abort_tx_idle: got a low tx cycle required all 1");
        end
        bus_read(16'h0001, v);
        checks++;
        if (v !== 16'h0002) begin
            failures++;
            $display("FAIL abort_status: got %h required 0002", v);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_tx_single();
        test_back_to_back();
        test_rx_single();
        test_overflow();
        test_ferr_glitch();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
